// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: register file, immediate extender, operand forwarding,
// load-use detection and ID/EX register. Optional macro ID_FWD_EN enables EX/MEM forwarding.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc4,
  input  logic [2:0]      sext_op,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic [RAW-1:0]  ex_wr,
  input  logic [XLEN-1:0] ex_wd,
  input  logic            mem_we,
  input  logic [RAW-1:0]  mem_wr,
  input  logic [XLEN-1:0] mem_wd,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_wr,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            stall_in,
  input  logic            flush,
  output logic            id_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rD1,
  output logic [XLEN-1:0] ex_rD2,
  output logic [XLEN-1:0] ex_ext,
  output logic [RAW-1:0]  ex_rd,
  output logic            ex_rf_we,
  output logic            ex_load,
  output logic [XLEN-1:0] ex_pc4
);

  logic [XLEN-1:0] rf_q [NREG];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, ext_q, ext_d, pc4_q, pc4_d;
  logic [RAW-1:0]  rd_q, rd_d;
  logic            rf_we_q, rf_we_d, load_q, load_d;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            luh;

  logic unused_bits;
`ifdef ID_FWD_EN
  assign unused_bits = ^if_inst[6:0];
`else
  assign unused_bits = ^{if_inst[6:0], ex_wd, mem_wd};
`endif

  // x0 is never written, so its array slot stays unused and reads are masked below.
  always_ff @(posedge clk) begin
    if (wb_we && wb_wr != '0) begin
      rf_q[wb_wr] <= wb_wd;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [RAW-1:0]  idx;
    logic [XLEN-1:0] val;
    logic            hz;

    assign idx = (gi == 0) ? if_inst[15 +: RAW] : if_inst[20 +: RAW];

    always_comb begin
      val = rf_q[idx];
      if (idx == '0) begin
        val = '0;
      end
`ifdef ID_FWD_EN
      else if (ex_we && !ex_is_load && ex_wr == idx) begin
        val = ex_wd;
      end else if (mem_we && mem_wr == idx) begin
        val = mem_wd;
      end
`endif
      else if (wb_we && wb_wr == idx) begin
        val = wb_wd;
      end
    end

    // Without forwarding, any in-flight EX/MEM producer must drain to WB first.
    always_comb begin
      hz = (idx != '0) && ((valid_q && ex_is_load && ex_we && ex_wr == idx)
`ifndef ID_FWD_EN
           || (ex_we && ex_wr == idx) || (mem_we && mem_wr == idx)
`endif
           );
    end
  end

  assign luh      = if_valid && (g_op[0].hz || g_op[1].hz);
  assign id_ready = !stall_in && !luh;

  always_comb begin
    imm32 = '0;
    case (sext_op)
      3'd0: imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      3'd1: imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      3'd2: imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                     if_inst[11:8], 1'b0};
      3'd3: imm32 = {if_inst[31:12], 12'b0};
      3'd4: imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                     if_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  always_comb begin
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    ext_d   = ext_q;
    pc4_d   = pc4_q;
    rd_d    = rd_q;
    rf_we_d = rf_we_q;
    load_d  = load_q;
    if (flush || (!stall_in && luh)) begin
      valid_d = 1'b0;
      rf_we_d = 1'b0;
      load_d  = 1'b0;
    end else if (!stall_in) begin
      valid_d = if_valid;
      rd1_d   = g_op[0].val;
      rd2_d   = g_op[1].val;
      ext_d   = imm_ext;
      pc4_d   = if_pc4;
      rd_d    = if_inst[7 +: RAW];
      rf_we_d = if_valid && id_we;
      load_d  = if_valid && id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ext_q   <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
      rf_we_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ext_q   <= ext_d;
      pc4_q   <= pc4_d;
      rd_q    <= rd_d;
      rf_we_q <= rf_we_d;
      load_q  <= load_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_rD1   = rd1_q;
  assign ex_rD2   = rd2_q;
  assign ex_ext   = ext_q;
  assign ex_pc4   = pc4_q;
  assign ex_rd    = rd_q;
  assign ex_rf_we = rf_we_q;
  assign ex_load  = load_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, write-through, forwarding/hazards,
// flush vs stall, immediates and mid-run reset.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst, if_valid, id_we, id_is_load, ex_we, ex_is_load, mem_we, wb_we;
  logic        stall_in, flush;
  logic [31:0] if_inst, if_pc4, ex_wd, mem_wd, wb_wd;
  logic [2:0]  sext_op;
  logic [4:0]  ex_wr, mem_wr, wb_wr;
  logic        id_ready, ex_valid, ex_rf_we, ex_load;
  logic [31:0] ex_rD1, ex_rD2, ex_ext, ex_pc4;
  logic [4:0]  ex_rd;
  int errors = 0;
  int checks = 0;

  id_stage_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
    .sext_op(sext_op), .id_we(id_we), .id_is_load(id_is_load),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wr(ex_wr), .ex_wd(ex_wd),
    .mem_we(mem_we), .mem_wr(mem_wr), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .stall_in(stall_in), .flush(flush), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_ext(ex_ext),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_load(ex_load), .ex_pc4(ex_pc4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_valid = 0; if_inst = '0; if_pc4 = '0; sext_op = '0; id_we = 0;
    id_is_load = 0; ex_we = 0; ex_is_load = 0; ex_wr = '0; ex_wd = '0; mem_we = 0;
    mem_wr = '0; mem_wd = '0; wb_we = 0; wb_wr = '0; wb_wd = '0; stall_in = 0; flush = 0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_rd1", ex_rD1, 0);
    chk("rst_rd2", ex_rD2, 0);
    chk("rst_ext", ex_ext, 0);
    chk("rst_ready", id_ready, 1);

    // addi x6,x5,-1 with x5 written through from WB in the same cycle
    wb_we = 1; wb_wr = 5; wb_wd = 32'hDEADBEEF;
    if_valid = 1; if_inst = 32'hFFF28313; if_pc4 = 32'h104; sext_op = 0; id_we = 1;
    #1 chk("wt_ready", id_ready, 1);
    step();
    chk("wt_valid", ex_valid, 1);
    chk("wt_rd1", ex_rD1, 32'hDEADBEEF);
    chk("wt_ext", ex_ext, 32'hFFFFFFFF);
    chk("wt_rd", ex_rd, 6);
    chk("wt_rfwe", ex_rf_we, 1);
    chk("wt_pc4", ex_pc4, 32'h104);

    wb_we = 0; if_pc4 = 32'h108;
    step();
    chk("rf_rd1", ex_rD1, 32'hDEADBEEF);

    // addi x9,x0,5 while WB attempts x0; rs2 field decodes to x5
    wb_we = 1; wb_wr = 0; wb_wd = 32'h1234; if_inst = 32'h00500493;
    step();
    chk("x0_wt_rd1", ex_rD1, 0);
    chk("x0_ext", ex_ext, 5);
    chk("x0_rd2", ex_rD2, 32'hDEADBEEF);
    wb_we = 0;
    step();
    chk("x0_rf_rd1", ex_rD1, 0);

    // addi x4,x3,0 with x3 pending in EX, MEM and WB
    if_inst = 32'h00018213;
    ex_we = 1; ex_is_load = 0; ex_wr = 3; ex_wd = 1;
    mem_we = 1; mem_wr = 3; mem_wd = 2;
    wb_we = 1; wb_wr = 3; wb_wd = 3;
`ifdef ID_FWD_EN
    #1 chk("fwd_ready", id_ready, 1);
    step(); chk("fwd_ex", ex_rD1, 1);
    ex_we = 0;
    step(); chk("fwd_mem", ex_rD1, 2);
    mem_we = 0;
    step(); chk("fwd_wb", ex_rD1, 3);
`else
    #1 chk("nofwd_ready_ex", id_ready, 0);
    step(); chk("nofwd_bub_ex", ex_valid, 0);
    ex_we = 0;
    #1 chk("nofwd_ready_mem", id_ready, 0);
    step(); chk("nofwd_bub_mem", ex_valid, 0);
    mem_we = 0;
    #1 chk("nofwd_ready_wb", id_ready, 1);
    step();
    chk("nofwd_valid_wb", ex_valid, 1);
    chk("nofwd_wb", ex_rD1, 3);
`endif
    wb_we = 0;

    // add x8,x7,x1 behind a load to x7
    if_inst = 32'h00138433; sext_op = 0;
    ex_we = 1; ex_is_load = 1; ex_wr = 7; ex_wd = 32'h99;
    #1 chk("luh_ready", id_ready, 0);
    step();
    chk("luh_bubble", ex_valid, 0);
    chk("luh_rfwe", ex_rf_we, 0);
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_wr = 7; mem_wd = 32'h55;
`ifdef ID_FWD_EN
    #1 chk("luh_ready2", id_ready, 1);
    step();
`else
    #1 chk("luh_ready_mem", id_ready, 0);
    step();
    chk("luh_bubble_mem", ex_valid, 0);
    mem_we = 0; wb_we = 1; wb_wr = 7; wb_wd = 32'h55;
    #1 chk("luh_ready2", id_ready, 1);
    step();
`endif
    chk("luh_valid", ex_valid, 1);
    chk("luh_rd1", ex_rD1, 32'h55);
    chk("luh_rd", ex_rd, 8);
    mem_we = 0; wb_we = 0;

    // flush beats stall, then stall holds for 3 cycles
    stall_in = 1; flush = 1;
    #1 chk("fs_ready", id_ready, 0);
    step();
    chk("fs_valid", ex_valid, 0);
    stall_in = 0; flush = 0; if_inst = 32'hFFF28313; if_pc4 = 32'h200;
    step();
    chk("cap_rd1", ex_rD1, 32'hDEADBEEF);
    stall_in = 1; if_inst = 32'h00500493; if_pc4 = 32'h300; id_we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", ex_valid, 1);
      chk("hold_ext", ex_ext, 32'hFFFFFFFF);
      chk("hold_rd", ex_rd, 6);
      chk("hold_pc4", ex_pc4, 32'h200);
      chk("hold_rfwe", ex_rf_we, 1);
    end
    stall_in = 0;

    // immediates
    if_inst = 32'hFE000EE3; sext_op = 2; id_we = 0;
    step();
    chk("imm_b", ex_ext, 32'hFFFFFFFC);
    chk("imm_b_rfwe", ex_rf_we, 0);
    if_inst = 32'h12345037; sext_op = 3; id_is_load = 1;
    step();
    chk("imm_u", ex_ext, 32'h12345000);
    chk("load_flag", ex_load, 1);
    sext_op = 5; id_is_load = 0;
    step();
    chk("imm_none", ex_ext, 0);

    // mid-run reset keeps register contents
    rst = 1;
    step();
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_pc4", ex_pc4, 0);
    rst = 0; if_inst = 32'hFFF28313; sext_op = 0; if_pc4 = 32'h400;
    step();
    chk("mrst_rf", ex_rD1, 32'hDEADBEEF);
    chk("mrst_pc4b", ex_pc4, 32'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle decode stage.
- Holds the register file and immediate sign-extender, with write-through bypass and operand forwarding from EX/MEM/WB.
- Detects load-use hazards and registers the decoded operands into an ID/EX pipeline register with valid/stall/flush control.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32: datapath width. Immediates are sign-extended to XLEN; instructions are always 32 bits.
- NREG, 32: number of architectural registers. Power of two, 2..32.
- RAW, $clog2(NREG): register index width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset. Synchronous, active-high.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_inst  in  32  instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7], low RAW bits used.
- if_pc4  in  XLEN  PC+4 of the instruction.
- sext_op  in  3  immediate type: 0 I, 1 S, 2 B, 3 U, 4 J, others give 0.
- id_we  in  1  decoded instruction writes rd.
- id_is_load  in  1  decoded instruction is a load.
- ex_we, ex_is_load  in  1 each  instruction currently in EX writes rd / is a load.
- ex_wr  in  RAW  EX destination.
- ex_wd  in  XLEN  EX result.
- mem_we  in  1  MEM writes rd.
- mem_wr  in  RAW  MEM destination.
- mem_wd  in  XLEN  MEM result (ALU or load data).
- wb_we  in  1  WB write enable.
- wb_wr  in  RAW  WB destination.
- wb_wd  in  XLEN  WB data.
- stall_in  in  1  downstream stall; hold the ID/EX register.
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- id_ready  out  1  ID accepts if_inst this cycle.
- ex_valid  out  1  ID/EX register valid.
- ex_rD1, ex_rD2  out  XLEN  forwarded operands.
- ex_ext  out  XLEN  sign-extended immediate.
- ex_rd  out  RAW  destination.
- ex_rf_we, ex_load  out  1 each  registered id_we / id_is_load.
- ex_pc4  out  XLEN  registered PC+4.

Behaviour:
- Register file:
  - NREG x XLEN; x0 reads 0 and is never written.
  - Write at posedge when wb_we && wb_wr != 0.
  - Register contents are not cleared by rst.
- Read path: combinational.
- Per-operand source priority (index != 0 only): EX (ex_we && !ex_is_load && ex_wr match) > MEM (mem_we && match) > WB (wb_we && match, write-through) > RF array. Index 0 always yields 0.
- Immediates:
  - I = inst[31:20].
  - S = {inst[31:25],inst[11:7]}.
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U = {inst[31:12],12'b0}.
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All sign-extended from bit 31 of the instruction to XLEN.
- Load-use hazard:
  - Condition: luh = if_valid && ex_valid && ex_is_load && ex_we && ex_wr != 0 && (ex_wr == rs1 || ex_wr == rs2).
  - rs2 is compared regardless of format; this is conservative by design.
- id_ready = !stall_in && !luh.
- ID/EX register update, priority order:
  1. rst: ex_valid = 0; all ex_* outputs = 0.
  2. flush: ex_valid = 0; data fields don't-care. Flush overrides stall_in and luh.
  3. stall_in: hold all fields.
  4. luh: ex_valid = 0 (bubble); IF must hold if_inst.
  5. Otherwise: capture; ex_valid = if_valid.
- Latency: exactly one cycle from if_inst to ex_* when unstalled.
- Bubble: ex_rf_we is forced to 0 whenever a bubble is inserted.
- Reset mid-operation: the pipeline register empties the next cycle; the RF retains its contents.

Optional Feature:
- Macro: ID_FWD_EN.
- Defined: EX/MEM forwarding as above.
- Undefined: the EX and MEM forwarding paths are removed; only the WB write-through remains. Any if_valid instruction whose rs1/rs2 (!= 0) matches a writing EX or MEM destination raises the hazard signal, so bubbles are inserted until the producer reaches WB.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles -> ex_valid=0, ex_rD1=ex_rD2=ex_ext=0, id_ready=1.
- WB write-through: wb_we=1, wb_wr=5, wb_wd=0xDEADBEEF, same cycle if_inst addi x6,x5,-1 (sext_op=0) -> next cycle ex_rD1=0xDEADBEEF, ex_ext=0xFFFFFFFF, ex_rd=6; write to x0 then read x0 -> 0.
- Forward priority (ID_FWD_EN): ex_wr=mem_wr=wb_wr=3 with ex_wd=1, mem_wd=2, wb_wd=3, inst uses rs1=3 -> ex_rD1=1; drop ex_we -> 2; drop mem_we -> 3.
- Load-use: ex_valid=1, ex_is_load=1, ex_wr=7, inst add x8,x7,x1 -> id_ready=0 and ex_valid=0 the next cycle; after the load leaves EX (mem_wd=0x55) -> ex_rD1=0x55.
- Flush vs stall: stall_in=1 and flush=1 together -> ex_valid=0 next cycle; stall_in alone -> ex_* held unchanged for 3 cycles.
- Immediates: B-type beq with offset -4 (inst=0xFE000EE3) -> ex_ext=0xFFFFFFFC; U-type inst=0x12345037 -> 0x12345000.
